// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch address sequencer with redirect, stall and halt control.
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   call, ret    link-register save/restore (only with PC_SEQ_LINK_EN defined)
//   fetch_req    registered fetch request, high only in FETCH
//   fetch_ack    memory accepts the request at pc this cycle
//   pc           current fetch address
//   instr_valid  one-cycle pulse after an accepted fetch
//   instr_pc     address of the completed fetch
//   br_valid     redirect request
//   br_target    redirect address
//   stall        hold sequencing
//   halt         stop fetching
//   resume       leave HALT
//   halted       high in HALT
// Optional feature macro: PC_SEQ_LINK_EN (call/ret with link register).
module pc_sequencer #(
    parameter int ADDR_W     = 4,
    parameter int RESET_ADDR = 0,
    parameter int STEP       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef PC_SEQ_LINK_EN
    input  logic              call,
    input  logic              ret,
`endif
    output logic              fetch_req,
    input  logic              fetch_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              stall,
    input  logic              halt,
    input  logic              resume,
    output logic              halted
);
    typedef enum logic [2:0] {START, FETCH, HOLD, REDIR, HALT} state_t;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] INC    = ADDR_W'(STEP);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx, ipc_nx, seq_pc;
    logic              ival_nx;

    assign seq_pc = pc + INC;

`ifdef PC_SEQ_LINK_EN
    logic [ADDR_W-1:0] link, link_nx;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ipc_nx   = instr_pc;
        ival_nx  = 1'b0;
`ifdef PC_SEQ_LINK_EN
        link_nx  = link;
`endif
        case (state)
            START: state_nx = FETCH;
            FETCH: begin
                if (fetch_ack) begin
                    ival_nx  = 1'b1;
                    ipc_nx   = pc;
`ifdef PC_SEQ_LINK_EN
                    // branch beats return; a call is a branch that also saves the fall-through
                    pc_nx    = br_valid ? br_target : (ret ? link : seq_pc);
                    link_nx  = (call && br_valid) ? seq_pc : link;
`else
                    pc_nx    = br_valid ? br_target : seq_pc;
`endif
                    state_nx = halt ? HALT : (stall ? HOLD : FETCH);
                end else if (br_valid) begin
                    pc_nx    = br_target;
                    state_nx = REDIR;
                end
                // unaccepted request without redirect: hold, ignoring halt/stall
            end
            REDIR: state_nx = FETCH;
            HOLD: begin
                pc_nx    = br_valid ? br_target : pc;
                state_nx = halt ? HALT : (stall ? HOLD : FETCH);
            end
            HALT: begin
                pc_nx    = br_valid ? br_target : pc;
                state_nx = (!halt && resume) ? FETCH : HALT;
            end
            default: state_nx = START;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= START;
            pc          <= RST_PC;
            instr_pc    <= RST_PC;
            instr_valid <= 1'b0;
            fetch_req   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            instr_pc    <= ipc_nx;
            instr_valid <= ival_nx;
            fetch_req   <= state_nx == FETCH;
            halted      <= state_nx == HALT;
        end
    end

`ifdef PC_SEQ_LINK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) link <= RST_PC;
        else          link <= link_nx;
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fetch_req, fetch_ack = 1'b0;
    logic [3:0] pc, instr_pc, br_target = 4'd0;
    logic       instr_valid, br_valid = 1'b0, stall = 1'b0, halt = 1'b0, resume = 1'b0, halted;
`ifdef PC_SEQ_LINK_EN
    logic       call = 1'b0, ret = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [3:0] exp_q[$];

    pc_sequencer dut (
        .clk(clk), .reset_n(reset_n),
`ifdef PC_SEQ_LINK_EN
        .call(call), .ret(ret),
`endif
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .pc(pc),
        .instr_valid(instr_valid), .instr_pc(instr_pc),
        .br_valid(br_valid), .br_target(br_target),
        .stall(stall), .halt(halt), .resume(resume), .halted(halted)
    );

    always #5 clk = ~clk;

    // monitor: every completed fetch must match the oldest expected address
    always @(negedge clk) begin
        if (instr_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL instr_valid: got pulse at instr_pc=%0d, required none", instr_pc);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (instr_pc !== e) begin
                    bad++;
                    $display("FAIL instr_pc: got %0d, required %0d", instr_pc, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input int e_pc, input int e_req, input int e_halt);
        chk({tag, " pc"}, int'(pc), e_pc);
        chk({tag, " fetch_req"}, int'(fetch_req), e_req);
        chk({tag, " halted"}, int'(halted), e_halt);
    endtask

    initial begin
        #2;
        chk("reset pc", int'(pc), 0);
        chk("reset instr_pc", int'(instr_pc), 0);
        chk("reset instr_valid", int'(instr_valid), 0);
        chk_st("reset", 0, 0, 0);
        step();
        reset_n = 1'b1;
        step();
        chk_st("start->fetch", 0, 1, 0);
        // back-to-back accepts 0..15,0..4 with wrap
        fetch_ack = 1'b1;
        for (int i = 0; i < 21; i++) begin
            chk("seq pc", int'(pc), i % 16);
            exp_q.push_back(4'(i % 16));
            step();
        end
        // unaccepted request at 5 holds
        fetch_ack = 1'b0;
        halt = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_st("wait ack", 5, 1, 0);
            step();
        end
        halt = 1'b0;
        stall = 1'b0;
        fetch_ack = 1'b1;
        exp_q.push_back(4'd5);
        step();
        chk_st("after ack5", 6, 1, 0);
        // accepted branch to 3
        br_valid = 1'b1;
        br_target = 4'd3;
        exp_q.push_back(4'd6);
        step();
        chk_st("br to 3", 3, 1, 0);
        // unaccepted redirect -> REDIR bubble
        fetch_ack = 1'b0;
        br_target = 4'd9;
        step();
        br_valid = 1'b0;
        chk_st("redir", 9, 0, 0);
        step();
        chk_st("redir done", 9, 1, 0);
        // get to 7 and halt on accept
        fetch_ack = 1'b1;
        br_valid = 1'b1;
        br_target = 4'd7;
        exp_q.push_back(4'd9);
        step();
        br_valid = 1'b0;
        halt = 1'b1;
        exp_q.push_back(4'd7);
        step();
        fetch_ack = 1'b0;
        chk_st("halt", 8, 0, 1);
        resume = 1'b1;
        step();
        chk_st("halt beats resume", 8, 0, 1);
        halt = 1'b0;
        step();
        resume = 1'b0;
        chk_st("resume", 8, 1, 0);
        // stall into HOLD, redirect while held, release
        fetch_ack = 1'b1;
        stall = 1'b1;
        exp_q.push_back(4'd8);
        step();
        fetch_ack = 1'b0;
        chk_st("hold", 9, 0, 0);
        br_valid = 1'b1;
        br_target = 4'd6;
        step();
        br_valid = 1'b0;
        chk_st("hold br", 6, 0, 0);
        stall = 1'b0;
        step();
        chk_st("hold release", 6, 1, 0);
        // async reset mid-handshake at pc=6
        fetch_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_st("async reset", 0, 0, 0);
        step();
        step();
        chk("reset no valid", int'(instr_valid), 0);
        reset_n = 1'b1;
        fetch_ack = 1'b0;
        step();
        chk_st("re-start", 0, 1, 0);
`ifdef PC_SEQ_LINK_EN
        fetch_ack = 1'b1;
        br_valid = 1'b1;
        br_target = 4'd2;
        exp_q.push_back(4'd0);
        step();
        call = 1'b1;
        br_target = 4'd12;
        exp_q.push_back(4'd2);
        step();
        call = 1'b0;
        br_valid = 1'b0;
        chk("call pc", int'(pc), 12);
        chk("link", int'(dut.link), 3);
        ret = 1'b1;
        exp_q.push_back(4'd12);
        step();
        ret = 1'b0;
        fetch_ack = 1'b0;
        chk("ret pc", int'(pc), 3);
`endif
        step();
        step();
        chk("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
